// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: loads feature map / weight bank from host bursts and
// streams each kernel into the convolution engine, one engine run per kernel.
module conv_layer_sequencer #(
  parameter int DATA_W      = 16,
  parameter int KM          = 3,
  parameter int KN          = 3,
  parameter int NUM_KERNELS = 4,
  parameter int W_ADDR_W    = 8,
  parameter int FM_ADDR_W   = 10,
  localparam int KI_W       = $clog2(NUM_KERNELS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_sel,
  input  logic                 wr_en,
  input  logic [DATA_W-1:0]    mem_in,
  input  logic                 start,
  input  logic                 abort,
  output logic                 eng_wr,
  output logic                 eng_sel,
  output logic [FM_ADDR_W-1:0] eng_addr,
  output logic [DATA_W-1:0]    eng_data,
  output logic                 eng_start,
  input  logic                 eng_done,
  output logic [KI_W-1:0]      kernel_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 load_ovf
);
  localparam int N  = KM * KN;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [2:0] {IDLE, LOAD_FM, LOAD_W, PRELOAD, RUN, FINISH} state_t;
  state_t                state_q, state_d;
  logic                  eng_wr_q, eng_wr_d, eng_sel_q, eng_sel_d, eng_start_q, eng_start_d;
  logic [FM_ADDR_W-1:0]  eng_addr_q, eng_addr_d;
  logic [DATA_W-1:0]     eng_data_q, eng_data_d;
  logic [KI_W-1:0]       kidx_q, kidx_d;
  logic                  busy_q, done_q, done_d, ovf_q, ovf_d;
  logic [W_ADDR_W:0]     w_cnt_q, w_cnt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ram_we;
  logic [W_ADDR_W-1:0]   ram_wa, rd_addr;
  logic [DATA_W-1:0]     ram [2**W_ADDR_W];
  assign rd_addr = W_ADDR_W'(int'(kidx_q) * N + int'(cnt_q));
  // w_cnt_q MSB set means the RAM is full; further words only flag overflow
  always_comb begin
    state_d     = state_q;
    eng_wr_d    = 1'b0;
    eng_sel_d   = eng_sel_q;
    eng_addr_d  = eng_addr_q;
    eng_data_d  = eng_data_q;
    eng_start_d = 1'b0;
    kidx_d      = kidx_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    w_cnt_d     = w_cnt_q;
    cnt_d       = cnt_q;
    ram_we      = 1'b0;
    ram_wa      = w_cnt_q[W_ADDR_W-1:0];
    if (abort) begin
      state_d = IDLE;
      kidx_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en && mem_sel) begin
            state_d = LOAD_W;
            ram_we  = 1'b1;
            ram_wa  = '0;
            w_cnt_d = (W_ADDR_W+1)'(1);
            ovf_d   = 1'b0;
          end else if (wr_en) begin
            state_d    = LOAD_FM;
            eng_wr_d   = 1'b1;
            eng_sel_d  = 1'b0;
            eng_addr_d = '0;
            eng_data_d = mem_in;
          end else if (start) begin
            state_d = PRELOAD;
            kidx_d  = '0;
            cnt_d   = '0;
          end
        end
        LOAD_FM: begin
          if (wr_en) begin
            eng_wr_d   = 1'b1;
            eng_addr_d = eng_addr_q + FM_ADDR_W'(1);
            eng_data_d = mem_in;
          end else state_d = IDLE;
        end
        LOAD_W: begin
          if (!wr_en) state_d = IDLE;
          else if (w_cnt_q[W_ADDR_W]) ovf_d = 1'b1;
          else begin
            ram_we  = 1'b1;
            w_cnt_d = w_cnt_q + (W_ADDR_W+1)'(1);
          end
        end
        PRELOAD: begin
          if (cnt_q == CW'(N)) begin
            eng_start_d = 1'b1;
            state_d     = RUN;
          end else begin
            eng_wr_d   = 1'b1;
            eng_sel_d  = 1'b1;
            eng_addr_d = FM_ADDR_W'(cnt_q);
            eng_data_d = ram[rd_addr];
            cnt_d      = cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (eng_done && kidx_q == KI_W'(NUM_KERNELS - 1)) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else if (eng_done) begin
            state_d = PRELOAD;
            kidx_d  = kidx_q + KI_W'(1);
            cnt_d   = '0;
          end
        end
        FINISH: begin
          state_d = IDLE;
          kidx_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      eng_wr_q    <= 1'b0;
      eng_sel_q   <= 1'b0;
      eng_addr_q  <= '0;
      eng_data_q  <= '0;
      eng_start_q <= 1'b0;
      kidx_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      w_cnt_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      eng_wr_q    <= eng_wr_d;
      eng_sel_q   <= eng_sel_d;
      eng_addr_q  <= eng_addr_d;
      eng_data_q  <= eng_data_d;
      eng_start_q <= eng_start_d;
      kidx_q      <= kidx_d;
      busy_q      <= state_d != IDLE;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      w_cnt_q     <= w_cnt_d;
      cnt_q       <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram[ram_wa] <= mem_in;
  end
  assign eng_wr     = eng_wr_q;
  assign eng_sel    = eng_sel_q;
  assign eng_addr   = eng_addr_q;
  assign eng_data   = eng_data_q;
  assign eng_start  = eng_start_q;
  assign kernel_idx = kidx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ovf   = ovf_q;
endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Parametrised multi-kernel sequencer for the convolution accelerator. It accepts host bursts that load either the feature map into the convolution engine or a bank of kernels into its internal weight RAM. On `start` it streams kernel k into the engine's weight buffer, fires the engine and waits for completion, then repeats for k = 0..NUM_KERNELS-1. It sits between the host/DMA write port and `conv_top`, replacing the fixed-size single-path wrapper with generic kernel geometry, an abort path and status reporting.

## Interface

- DATA_W, 16: data word width.
- KM, 3: kernel rows.
- KN, 3: kernel columns.
- NUM_KERNELS, 4: kernels per layer, ≥1.
- W_ADDR_W, 8: weight RAM address width. Depth is 2^W_ADDR_W, which must be ≥ NUM_KERNELS·KM·KN.
- FM_ADDR_W, 10: engine feature/weight address width.

- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- mem_sel  in  1  burst target: 1 = weights, 0 = feature map. Sampled on the first `wr_en` cycle only.
- wr_en  in  1  burst valid. One word per cycle; a burst ends when `wr_en` is low.
- mem_in  in  DATA_W  burst data.
- start  in  1  start-layer pulse.
- abort  in  1  abandon the current operation.
- eng_wr  out  1  engine buffer write strobe.
- eng_sel  out  1  engine buffer select: 0 = feature, 1 = weight.
- eng_addr  out  FM_ADDR_W  engine buffer address.
- eng_data  out  DATA_W  engine write data.
- eng_start  out  1  one-cycle engine start pulse.
- eng_done  in  1  engine completion pulse.
- kernel_idx  out  $clog2(NUM_KERNELS+1)  kernel currently being processed.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the layer completes.
- load_ovf  out  1  sticky flag: the last weight burst exceeded RAM depth.

## Operation

- States: IDLE, LOAD_FM, LOAD_W, PRELOAD, RUN, FINISH.
- IDLE:
  - If `wr_en`, go to LOAD_FM when `mem_sel`=0 or LOAD_W when `mem_sel`=1. That first word is accepted.
  - Else if `start`, set kernel_idx=0 and go to PRELOAD.
  - If `wr_en` and `start` are high together, `wr_en` wins and `start` is dropped.
- LOAD_FM: each accepted word is registered onto `eng_data` with `eng_wr`=1, `eng_sel`=0. `eng_addr` starts at 0 and increments per word, wrapping modulo 2^FM_ADDR_W. Return to IDLE on the first `wr_en`=0 cycle.
- LOAD_W:
  - Words are written to weight RAM at address 0, 1, 2, …
  - Words beyond the last RAM address are discarded and set `load_ovf`.
  - `load_ovf` clears at the start of the next weight burst.
  - Return to IDLE on `wr_en`=0.
- PRELOAD:
  - Issue N = KM·KN reads at base kernel_idx·N.
  - The RAM has one-cycle read latency. Each returned word drives `eng_wr`=1, `eng_sel`=1, `eng_addr`=0..N-1.
  - After the last write, pulse `eng_start` and enter RUN.
- RUN: wait for `eng_done`.
  - On `eng_done`: if kernel_idx = NUM_KERNELS-1, go to FINISH; otherwise increment kernel_idx and go to PRELOAD.
  - `eng_done` outside RUN is ignored.
- FINISH: pulse `done` for one cycle, then go to IDLE and clear kernel_idx to 0.
- `start` outside IDLE is ignored.
- `abort` in any state: next cycle is IDLE. `eng_wr`/`eng_start` drop in that same next cycle, no `done` is produced, and kernel_idx clears. The weight RAM contents are preserved.
- All outputs are registered.

## Timing

- Reset values:
  - state = IDLE.
  - `eng_wr`, `eng_sel`, `eng_start`, `busy`, `done`, `load_ovf` = 0.
  - `eng_addr`, `eng_data`, kernel_idx = 0.
  - Weight RAM is not cleared.
- Reset mid-operation behaves identically to `abort`, and additionally clears `load_ovf`.
- Feature load: word accepted at cycle c appears on `eng_data`/`eng_wr` at c+1.
- Weight load: word accepted at cycle c is readable from c+1.
- Layer sequence, with `start` sampled at cycle t:
  - PRELOAD reads occur at t+1..t+N.
  - `eng_wr` is high at t+2..t+N+1.
  - `eng_start` pulses at t+N+2.
- `eng_done` at cycle d:
  - next kernel's first read at d+1, or
  - `done` at d+1 for the last kernel.
- `busy` rises at t+1 and falls in the cycle after `done`.

## Test plan

- Reset: assert `rst` for 2 cycles, then check all outputs are 0, `busy`=0, and kernel_idx=0.
- Feature burst: 5 words 0x11..0x15 with `mem_sel`=0 → `eng_wr` high for 5 cycles, `eng_addr` 0..4, `eng_data` 0x11..0x15, `eng_sel`=0. Return to IDLE.
- Full layer, KM=KN=3, NUM_KERNELS=2:
  - Load 18 weights with value = address.
  - `start` → first PRELOAD writes data 0..8 at `eng_addr` 0..8, then `eng_start` at t+11.
  - `eng_done` → second PRELOAD writes data 9..17.
  - Second `eng_done` → single `done` pulse; `eng_done` count = 2.
- Overflow, W_ADDR_W=4: 20-word weight burst → addresses 0..15 written, `load_ovf`=1. A following 1-word burst clears `load_ovf`.
- Abort: `abort` during RUN of kernel 1 → IDLE next cycle, no `done`. A new `start` restarts from kernel 0 with the weights intact.
- Simultaneous: `start` and `wr_en` high together in IDLE → feature load performed, no PRELOAD. `start` during RUN is ignored.
